// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the five-stage core.
// It latches the decoded operands and control coming from ID. It loads a
// bubble on a flush, on a load-use hazard, or when ID holds no real
// instruction. It applies EX/MEM and MEM/WB forwarding to the latched rs and
// rt values, and drives the ALU operand and op-select inputs.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-low reset
//   id_*                            decoded instruction fields from ID
//   flush                           kill the instruction entering EX
//   em_reg_write/em_wa/em_data      EX/MEM writeback info for forwarding
//   mw_reg_write/mw_wa/mw_data      MEM/WB writeback info for forwarding
//   stall                           combinational load-use hold for PC and IF/ID
//   alu_a/alu_b/alu_sel             forwarded ALU operands and op
//   ex_store_data                   forwarded rt, used by stores
//   ex_valid/ex_reg_write/ex_mem_read/ex_mem_write/ex_wa/ex_pc  EX control
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs_val,
  input  logic [WIDTH-1:0] id_rt_val,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_wa,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [2:0]       id_alu_sel,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             flush,
  input  logic             em_reg_write,
  input  logic [RA_W-1:0]  em_wa,
  input  logic [WIDTH-1:0] em_data,
  input  logic             mw_reg_write,
  input  logic [RA_W-1:0]  mw_wa,
  input  logic [WIDTH-1:0] mw_data,
  output logic             stall,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [RA_W-1:0]  ex_wa,
  output logic [WIDTH-1:0] ex_pc
);

  logic             valid_q,     valid_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q,  mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             alu_src_q,   alu_src_d;
  logic [WIDTH-1:0] pc_q,        pc_d;
  logic [WIDTH-1:0] rs_val_q,    rs_val_d;
  logic [WIDTH-1:0] rt_val_q,    rt_val_d;
  logic [RA_W-1:0]  rs_q,        rs_d;
  logic [RA_W-1:0]  rt_q,        rt_d;
  logic [RA_W-1:0]  wa_q,        wa_d;
  logic [WIDTH-1:0] imm_q,       imm_d;
  logic [2:0]       sel_q,       sel_d;

  logic             rt_used;
  logic             bubble;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // A load in EX whose destination is read by ID cannot be forwarded yet.
  // Hold ID for exactly one cycle; the load then forwards from MEM/WB.
  always_comb begin
    rt_used = !id_alu_src || id_mem_write;
    stall   = id_valid && valid_q && mem_read_q && (wa_q != '0) &&
              ((wa_q == id_rs) || (rt_used && (wa_q == id_rt)));
  end

  // A flush, a stall, or an empty ID slot all load an all-zero bubble.
  always_comb begin
    bubble      = flush || stall || !id_valid;
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_src_d   = 1'b0;
    pc_d        = '0;
    rs_val_d    = '0;
    rt_val_d    = '0;
    rs_d        = '0;
    rt_d        = '0;
    wa_d        = '0;
    imm_d       = '0;
    sel_d       = '0;
    if (!bubble) begin
      valid_d     = 1'b1;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      alu_src_d   = id_alu_src;
      pc_d        = id_pc;
      rs_val_d    = id_rs_val;
      rt_val_d    = id_rt_val;
      rs_d        = id_rs;
      rt_d        = id_rt;
      wa_d        = id_wa;
      imm_d       = id_imm;
      sel_d       = id_alu_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      pc_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      wa_q        <= '0;
      imm_q       <= '0;
      sel_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_src_q   <= alu_src_d;
      pc_q        <= pc_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wa_q        <= wa_d;
      imm_q       <= imm_d;
      sel_q       <= sel_d;
    end
  end

  // Forwarding: EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
  always_comb begin
    fwd_rs = rs_val_q;
    if (em_reg_write && (em_wa != '0) && (em_wa == rs_q))
      fwd_rs = em_data;
    else if (mw_reg_write && (mw_wa != '0) && (mw_wa == rs_q))
      fwd_rs = mw_data;

    fwd_rt = rt_val_q;
    if (em_reg_write && (em_wa != '0) && (em_wa == rt_q))
      fwd_rt = em_data;
    else if (mw_reg_write && (mw_wa != '0) && (mw_wa == rt_q))
      fwd_rt = mw_data;
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign alu_sel       = sel_q;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_wa         = wa_q;
  assign ex_pc         = pc_q;

endmodule
